// File: rtl/beta_pipe_stage.sv
// Elastic pipeline register: Depth-entry circular buffer with valid/ready
// handshaking, global stall and synchronous flush. Payload is never interpreted.
module beta_pipe_stage #(
   parameter int PayloadWidth = 32,
   parameter int Depth        = 2,
   parameter int CountWidth   = $clog2(Depth + 1)
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic [PayloadWidth-1:0] pip_data_i,
   input  logic                    pip_valid_i,
   output logic                    pip_ready_o,
   output logic [PayloadWidth-1:0] pip_data_o,
   output logic                    pip_valid_o,
   input  logic                    pip_ready_i,
   input  logic                    pip_stall_i,
   input  logic                    pip_flush_i,
   output logic [CountWidth-1:0]   pip_count_o
);

   localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [CountWidth-1:0] CountFull = CountWidth'(Depth);
   localparam logic [PtrWidth-1:0]   PtrLast   = PtrWidth'(Depth - 1);

   logic [PayloadWidth-1:0] mem_q [Depth];
   logic [PtrWidth-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CountWidth-1:0]   count_q, count_d;
   logic [PayloadWidth-1:0] head_data;
   logic                    push;
   logic                    pop;

   // Ready depends only on registered occupancy and stall, never on pip_ready_i.
   assign pip_ready_o = (count_q != CountFull) && !pip_stall_i;
   assign pip_valid_o = (count_q != '0);
   assign push        = pip_valid_i && pip_ready_o && !pip_flush_i;
   assign pop         = pip_valid_o && pip_ready_i && !pip_stall_i && !pip_flush_i;
   assign pip_count_o = count_q;
   assign pip_data_o  = pip_valid_o ? head_data : '0;

   always_comb begin
      head_data = '0;
      for (int i = 0; i < Depth; i++) begin
         if (rd_ptr_q == PtrWidth'(i)) begin
            head_data = mem_q[i];
         end
      end
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (pip_flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is cleared on reset and flush so a bubble never carries stale data.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (pip_flush_i) begin
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < Depth; i++) begin
            if (push && (wr_ptr_q == PtrWidth'(i))) begin
               mem_q[i] <= pip_data_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_beta_pipe_stage.sv
// Scoreboard bench for beta_pipe_stage: Depth=2 (streaming), Depth=4
// (backpressure, stall, flush, async reset) and Depth=1 (half throughput).
module tb_beta_pipe_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn;

   logic [7:0] a_din, a_dout;
   logic       a_vin, a_rdy_o, a_vout, a_rdy_i, a_stall, a_flush;
   logic [1:0] a_cnt;

   logic [7:0] b_din, b_dout;
   logic       b_vin, b_rdy_o, b_vout, b_rdy_i, b_stall, b_flush;
   logic [2:0] b_cnt;

   logic [7:0] c_din, c_dout;
   logic       c_vin, c_rdy_o, c_vout, c_rdy_i, c_stall, c_flush;
   logic [0:0] c_cnt;

   beta_pipe_stage #(.PayloadWidth(8), .Depth(2)) u_a (
      .clk_i(clk), .rstn_i(rstn), .pip_data_i(a_din), .pip_valid_i(a_vin),
      .pip_ready_o(a_rdy_o), .pip_data_o(a_dout), .pip_valid_o(a_vout),
      .pip_ready_i(a_rdy_i), .pip_stall_i(a_stall), .pip_flush_i(a_flush),
      .pip_count_o(a_cnt));

   beta_pipe_stage #(.PayloadWidth(8), .Depth(4)) u_b (
      .clk_i(clk), .rstn_i(rstn), .pip_data_i(b_din), .pip_valid_i(b_vin),
      .pip_ready_o(b_rdy_o), .pip_data_o(b_dout), .pip_valid_o(b_vout),
      .pip_ready_i(b_rdy_i), .pip_stall_i(b_stall), .pip_flush_i(b_flush),
      .pip_count_o(b_cnt));

   beta_pipe_stage #(.PayloadWidth(8), .Depth(1)) u_c (
      .clk_i(clk), .rstn_i(rstn), .pip_data_i(c_din), .pip_valid_i(c_vin),
      .pip_ready_o(c_rdy_o), .pip_data_o(c_dout), .pip_valid_o(c_vout),
      .pip_ready_i(c_rdy_i), .pip_stall_i(c_stall), .pip_flush_i(c_flush),
      .pip_count_o(c_cnt));

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] qc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitors: a transfer is sampled mid-cycle and consumed at the next edge.
   always @(negedge clk) begin : mon_a
      logic [7:0] e;
      if (rstn === 1'b1 && a_vout && a_rdy_i && !a_stall && !a_flush) begin
         if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL A_extra: got 0x%0h, want no output", a_dout);
         end else begin
            e = qa.pop_front();
            chk("A_data", {24'h0, a_dout}, {24'h0, e});
            $display("[%0t] A out 0x%0h (exp 0x%0h)", $time, a_dout, e);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [7:0] e;
      if (rstn === 1'b1 && b_vout && b_rdy_i && !b_stall && !b_flush) begin
         if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL B_extra: got 0x%0h, want no output", b_dout);
         end else begin
            e = qb.pop_front();
            chk("B_data", {24'h0, b_dout}, {24'h0, e});
            $display("[%0t] B out 0x%0h (exp 0x%0h)", $time, b_dout, e);
         end
      end
   end

   always @(negedge clk) begin : mon_c
      logic [7:0] e;
      if (rstn === 1'b1 && c_vout && c_rdy_i && !c_stall && !c_flush) begin
         if (qc.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL C_extra: got 0x%0h, want no output", c_dout);
         end else begin
            e = qc.pop_front();
            chk("C_data", {24'h0, c_dout}, {24'h0, e});
            $display("[%0t] C out 0x%0h (exp 0x%0h)", $time, c_dout, e);
         end
      end
   end

   // Offer one beat on B and hold it until the stage shows ready.
   task automatic b_send(input logic [7:0] d, input bit track);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      b_vin = 1'b1; b_din = d;
      if (track) qb.push_back(d);
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (b_rdy_o) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL B_send_timeout: got ready=0, want ready=1 for 0x%0h", d);
      end
   endtask

   task automatic c_send(input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      c_vin = 1'b1; c_din = d;
      qc.push_back(d);
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (c_rdy_o) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL C_send_timeout: got ready=0, want ready=1 for 0x%0h", d);
      end
   endtask

   task automatic b_idle();
      @(posedge clk); #1;
      b_vin = 1'b0;
   endtask

   task automatic wait_empty_b();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (b_cnt == 3'd0) break;
      end
      chk("B_drain_count", {29'h0, b_cnt}, 32'd0);
   endtask

   task automatic wait_empty_c();
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (c_cnt == 1'b0) break;
      end
      chk("C_drain_count", {31'h0, c_cnt}, 32'd0);
   endtask

   logic [7:0] stream_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic       c_ready_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      rstn = 1'b0;
      a_din = '0; a_vin = 0; a_rdy_i = 0; a_stall = 0; a_flush = 0;
      b_din = '0; b_vin = 0; b_rdy_i = 0; b_stall = 0; b_flush = 0;
      c_din = '0; c_vin = 0; c_rdy_i = 0; c_stall = 0; c_flush = 0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("A_rst_valid", {31'h0, a_vout}, 32'd0);
      chk("A_rst_ready", {31'h0, a_rdy_o}, 32'd1);
      chk("A_rst_count", {30'h0, a_cnt}, 32'd0);
      chk("A_rst_data", {24'h0, a_dout}, 32'd0);

      // Streaming through Depth=2: occupancy settles at 1, ready never drops.
      @(posedge clk); #1; a_rdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         a_vin = 1'b1; a_din = stream_vals[i];
         qa.push_back(stream_vals[i]);
         @(negedge clk);
         chk("A_stream_ready", {31'h0, a_rdy_o}, 32'd1);
         if (i > 0) chk("A_stream_count", {30'h0, a_cnt}, 32'd1);
      end
      @(posedge clk); #1; a_vin = 1'b0;
      @(negedge clk);
      chk("A_stream_tail_count", {30'h0, a_cnt}, 32'd1);
      @(negedge clk);
      chk("A_stream_empty", {30'h0, a_cnt}, 32'd0);

      // Backpressure on Depth=4, then release; six payloads cross the wrap.
      for (int i = 0; i < 4; i++) b_send(8'hA0 + 8'(i), 1'b1);
      @(posedge clk); #1;
      b_vin = 1'b1; b_din = 8'hA4;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("B_full_count", {29'h0, b_cnt}, 32'd4);
         chk("B_full_ready", {31'h0, b_rdy_o}, 32'd0);
      end
      @(posedge clk); #1; b_rdy_i = 1'b1;
      b_send(8'hA4, 1'b1);
      b_send(8'hA5, 1'b1);
      b_idle();
      wait_empty_b();

      // Stall with two entries held and upstream/downstream both active.
      @(posedge clk); #1; b_rdy_i = 1'b0;
      b_send(8'h05, 1'b1);
      b_send(8'h06, 1'b1);
      @(posedge clk); #1;
      b_stall = 1'b1; b_vin = 1'b1; b_din = 8'h99; b_rdy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("B_stall_count", {29'h0, b_cnt}, 32'd2);
         chk("B_stall_data", {24'h0, b_dout}, 32'h05);
         chk("B_stall_ready", {31'h0, b_rdy_o}, 32'd0);
      end
      @(posedge clk); #1; b_stall = 1'b0; b_vin = 1'b0;
      @(negedge clk);
      chk("B_stall_release_count", {29'h0, b_cnt}, 32'd2);
      wait_empty_b();

      // Flush with a concurrent push: contents and 0x77 are discarded.
      @(posedge clk); #1; b_rdy_i = 1'b0;
      b_send(8'h31, 1'b0);
      b_send(8'h32, 1'b0);
      b_send(8'h33, 1'b0);
      @(posedge clk); #1;
      b_flush = 1'b1; b_vin = 1'b1; b_din = 8'h77;
      @(negedge clk);
      chk("B_preflush_count", {29'h0, b_cnt}, 32'd3);
      @(posedge clk); #1; b_flush = 1'b0; b_vin = 1'b0; b_rdy_i = 1'b1;
      @(negedge clk);
      chk("B_flush_count", {29'h0, b_cnt}, 32'd0);
      chk("B_flush_valid", {31'h0, b_vout}, 32'd0);
      chk("B_flush_data", {24'h0, b_dout}, 32'd0);
      repeat (3) @(negedge clk);

      // Flush and stall together behave like a plain flush.
      @(posedge clk); #1; b_rdy_i = 1'b0;
      b_send(8'h34, 1'b0);
      b_send(8'h35, 1'b0);
      @(posedge clk); #1;
      b_flush = 1'b1; b_stall = 1'b1; b_vin = 1'b1; b_din = 8'h78;
      @(negedge clk);
      chk("B_fs_pre_count", {29'h0, b_cnt}, 32'd2);
      @(posedge clk); #1; b_flush = 1'b0; b_stall = 1'b0; b_vin = 1'b0; b_rdy_i = 1'b1;
      @(negedge clk);
      chk("B_fs_count", {29'h0, b_cnt}, 32'd0);
      chk("B_fs_valid", {31'h0, b_vout}, 32'd0);
      chk("B_fs_data", {24'h0, b_dout}, 32'd0);
      b_send(8'h3C, 1'b1);
      b_idle();
      wait_empty_b();

      // Asynchronous reset mid-cycle with three entries stored.
      @(posedge clk); #1; b_rdy_i = 1'b0;
      b_send(8'h41, 1'b0);
      b_send(8'h42, 1'b0);
      b_send(8'h43, 1'b0);
      b_idle();
      @(negedge clk);
      chk("B_prerst_count", {29'h0, b_cnt}, 32'd3);
      #2 rstn = 1'b0;
      #1;
      chk("B_arst_count", {29'h0, b_cnt}, 32'd0);
      chk("B_arst_valid", {31'h0, b_vout}, 32'd0);
      chk("B_arst_data", {24'h0, b_dout}, 32'd0);
      chk("B_arst_ready", {31'h0, b_rdy_o}, 32'd1);
      @(negedge clk); rstn = 1'b1;
      @(negedge clk);
      chk("B_postrst_count", {29'h0, b_cnt}, 32'd0);

      // Depth=1: ready alternates, one payload every two cycles.
      @(posedge clk); #1; c_rdy_i = 1'b1;
      fork
         begin
            c_send(8'h01);
            c_send(8'h02);
            c_send(8'h03);
            @(posedge clk); #1; c_vin = 1'b0;
         end
         begin
            @(posedge clk); #1;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               chk("C_ready_toggle", {31'h0, c_rdy_o}, {31'h0, c_ready_pat[k]});
            end
         end
      join
      wait_empty_c();

      repeat (2) @(negedge clk);
      chk("A_left", qa.size(), 32'd0);
      chk("B_left", qb.size(), 32'd0);
      chk("C_left", qc.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/beta_pipe_stage.md
Name: beta_pipe_stage

Overview:
- Parametrised elastic pipeline register; generalises the fixed decode-to-execute register into a reusable stage for any inter-stage boundary (fetch/decode, decode/execute, execute/writeback).
- Carries an opaque payload of PayloadWidth bits through a Depth-entry circular buffer with valid/ready handshaking, global stall and flush.
- The Pipeline Control Unit drives stall/flush; the surrounding stages drive the handshakes.

Parameters:
- PayloadWidth, 32, width of the packed payload (e.g. control word, operands, pc); legal range ≥1.
- Depth, 2, number of buffer entries; legal range 1..16; need not be a power of two.
- CountWidth, $clog2(Depth+1), width of the occupancy output (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- pip_data_i  in  PayloadWidth  payload from upstream stage.
- pip_valid_i  in  1  upstream payload valid.
- pip_ready_o  out  1  stage can accept a payload this cycle.
- pip_data_o  out  PayloadWidth  payload at buffer head.
- pip_valid_o  out  1  head payload valid.
- pip_ready_i  in  1  downstream accepts head this cycle.
- pip_stall_i  in  1  global hold from Pipeline Control Unit.
- pip_flush_i  in  1  synchronous discard of all contents.
- pip_count_o  out  CountWidth  current occupancy, 0..Depth.

Behaviour:
- Reset (rstn_i=0, async): wr_ptr=rd_ptr=0, count=0, all storage entries cleared to '0. Outputs: pip_valid_o=0, pip_data_o='0, pip_ready_o=1, pip_count_o=0.
- Storage: Depth entries, wr_ptr/rd_ptr wrap from Depth-1 to 0 explicitly (no power-of-two masking).
- pip_ready_o = (count != Depth) && !pip_stall_i. It is a function of registered state and stall only; it never depends on pip_ready_i (no combinational ready path through the stage).
- push = pip_valid_i && pip_ready_o && !pip_flush_i.
- pop = pip_valid_o && pip_ready_i && !pip_stall_i && !pip_flush_i.
- pip_valid_o = (count != 0).
- pip_data_o = storage[rd_ptr] when count != 0, else '0. An empty stage always presents a zero payload, i.e. a bubble.
- Latency: a payload pushed at edge N is visible on pip_data_o/pip_valid_o after edge N when the stage was empty. Minimum latency is 1 cycle.
- Throughput: 1 payload per cycle when Depth ≥2 and downstream is ready. With Depth=1, a full stage deasserts ready, so throughput is 1 payload per 2 cycles.
- Simultaneous push and pop: count unchanged, both pointers advance. This is legal at any count < Depth. At count=Depth no push occurs because ready is low, even if a pop happens that cycle.
- Stall (pip_stall_i=1): no push, no pop. Pointers, count and storage are held. pip_valid_o/pip_data_o continue to show the head; downstream must not treat them as consumed.
- Flush (pip_flush_i=1): at the next edge wr_ptr=rd_ptr=count=0 and all storage is cleared to '0. A concurrent push is discarded. Flush has priority over stall and over any handshake. pip_ready_o is not masked by flush, so upstream may see ready=1, but the push is dropped.
- Reset asserted mid-operation: all state clears immediately, regardless of clock. Deassertion is synchronised externally.
- count never exceeds Depth and never underflows. Overflow or underflow is structurally impossible given the push/pop definitions.
- Payload bits are never interpreted. No X propagation from unwritten entries, because storage is reset.

Test Plan:
- Reset/bubble: hold rstn_i=0 mid-cycle with 3 entries stored → pip_valid_o=0, pip_data_o=0, pip_count_o=0, pip_ready_o=1 immediately, without waiting for a clock edge.
- Streaming, Depth=2: push 0x11,0x22,0x33,0x44 on consecutive cycles with pip_ready_i=1 → outputs appear 1 cycle later in order, count stays 1, and pip_ready_o stays 1 throughout.
- Backpressure/full, Depth=4: pip_ready_i=0, push 0xA0..0xA5 → after 4 accepts count=4 and pip_ready_o=0, so 0xA4/0xA5 are held upstream. Release pip_ready_i → order is 0xA0,0xA1,0xA2,0xA3,0xA4,0xA5 with no loss, and the pointers wrap at 3→0.
- Stall: with 2 entries (0x5,0x6) held, assert pip_stall_i for 3 cycles with pip_valid_i=1 and pip_ready_i=1 → count stays 2, pip_data_o stays 0x5, and no push is accepted. On release, 0x5 then 0x6 are delivered.
- Flush with concurrent push: count=3, assert pip_flush_i with pip_valid_i=1 and data 0x77 → next cycle count=0, pip_valid_o=0, pip_data_o=0, and 0x77 is never output. Flush+stall together gives the same result.
- Depth=1: continuous valid input of 0x1,0x2,0x3 with pip_ready_i=1 → one payload accepted every 2 cycles, pip_ready_o toggles 1,0,1,0, and the payloads are delivered in order.
